// File: rtl/ef_adc_pkg.sv
// Shared types and defaults for the ADC averaging / window-watchdog block.
package ef_adc_pkg;

   localparam int DW_DEF        = 8;
   localparam int NMAX_LOG2_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Clamp the requested averaging exponent to the largest supported window.
   function automatic logic [1:0] sat_log2(input logic [1:0] req, input int nmax);
      if (int'(req) > nmax) return 2'(nmax);
      else return req;
   endfunction

endpackage

// File: rtl/ef_adc_avg_wdg_if.sv
// FIFO-pop and result-handshake signals between the averager and its neighbours.
// Result handshake: res_data is stable while res_valid=1 and is consumed on a clk edge with res_valid & res_ready both high.
interface ef_adc_avg_wdg_if #(parameter int DW = ef_adc_pkg::DW_DEF);
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_rd;
   logic [DW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
   logic          win_flag;
   logic [7:0]    win_cnt;

   modport master (
      input  fifo_empty, fifo_data, res_ready,
      output fifo_rd, res_data, res_valid, win_flag, win_cnt
   );

   modport slave (
      output fifo_empty, fifo_data, res_ready,
      input  fifo_rd, res_data, res_valid, win_flag, win_cnt
   );
endinterface

// File: rtl/ef_adc_win_cmp.sv
// Combinational window check: flags a value outside [lo, hi] inclusive.
module ef_adc_win_cmp
   import ef_adc_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0] val,
   input  logic [DW-1:0] lo,
   input  logic [DW-1:0] hi,
   output logic          outside
);
   assign outside = (val < lo) | (val > hi);
endmodule

// File: rtl/ef_adc_avg_wdg.sv
// Averages 2^avg_log2 ADC FIFO samples, presents the result with a valid/ready
// handshake and counts results that fall outside the programmed window.
module ef_adc_avg_wdg
   import ef_adc_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int NMAX_LOG2 = NMAX_LOG2_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      avg_log2,
   input  logic [DW-1:0]   win_lo,
   input  logic [DW-1:0]   win_hi,
   output state_t          state_dbg,
   ef_adc_avg_wdg_if.master bus
);
   localparam int AW = DW + NMAX_LOG2;
   localparam int CW = NMAX_LOG2 + 1;

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_sum;
   logic [CW-1:0] cnt_q, cnt_inc, target;
   logic [1:0]    lat_q;
   logic [DW-1:0] res_q, res_next;
   logic [7:0]    wcnt_q;
   logic          flag_q, outside, pop, last_pop, enter_acc;

   // Pops are suppressed during reset so a mid-window reset never consumes data.
   assign pop       = ~rst & en & (state_q == ST_ACC) & ~bus.fifo_empty;
   assign acc_sum   = acc_q + AW'(bus.fifo_data);
   assign cnt_inc   = cnt_q + CW'(1);
   assign target    = CW'(1) << lat_q;
   assign last_pop  = pop & (cnt_inc == target);
   assign res_next  = DW'(acc_sum >> lat_q);
   assign enter_acc = (state_d == ST_ACC) & (state_q != ST_ACC);

   ef_adc_win_cmp #(.DW(DW)) u_win_cmp (
      .val     (res_next),
      .lo      (win_lo),
      .hi      (win_hi),
      .outside (outside)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         flag_q  <= 1'b0;
         if (enter_acc) begin
            acc_q <= '0;
            cnt_q <= '0;
            lat_q <= sat_log2(avg_log2, NMAX_LOG2);
         end else if (pop) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_inc;
         end
         // Result and window verdict are captured together so win_flag lines up with the first OUT cycle.
         if (last_pop) begin
            res_q  <= res_next;
            flag_q <= outside;
            if (outside && (wcnt_q != 8'hFF)) wcnt_q <= wcnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ACC;
            ST_ACC:  if (last_pop) state_d = ST_OUT;
            ST_OUT:  if (bus.res_ready) state_d = ST_ACC;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.fifo_rd   = pop;
      bus.res_valid = en & (state_q == ST_OUT);
      bus.res_data  = res_q;
      bus.win_flag  = flag_q;
      bus.win_cnt   = wcnt_q;
      state_dbg     = state_q;
   end
endmodule

// File: doc/ef_adc_avg_wdg.md
EF_ADC_AVG_WDG -- requirements
Module: ef_adc_avg_wdg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter DW SHALL default to 8 and set the sample/result width.
REQ-003 Parameter NMAX_LOG2 SHALL default to 3 and set the maximum averaging exponent (window of 8 samples).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  block enable; low forces IDLE.
REQ-007 fifo_empty  input  1  upstream ADC FIFO empty flag.
REQ-008 fifo_data  input  DW  upstream FIFO head word, valid while fifo_empty=0.
REQ-009 fifo_rd  output  1  pop strobe to upstream FIFO.
REQ-010 avg_log2  input  2  window size = 2^avg_log2 samples; values above NMAX_LOG2 saturate to NMAX_LOG2.
REQ-011 win_lo  input  DW  lower window bound, inclusive.
REQ-012 win_hi  input  DW  upper window bound, inclusive.
REQ-013 res_data  output  DW  averaged result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 win_flag  output  1  one-cycle pulse: result outside [win_lo, win_hi].
REQ-017 win_cnt  output  8  saturating count of window violations.

Function
REQ-018 FSM states SHALL be IDLE, ACC and OUT.
REQ-019 IDLE SHALL go to ACC when en=1; any state SHALL go to IDLE when en=0, discarding the partial sum and any pending result.
REQ-020 On entry to ACC, the block SHALL clear the accumulator (DW+NMAX_LOG2 bits) and the sample counter, and SHALL latch avg_log2; mid-window changes SHALL have no effect.
REQ-021 fifo_rd SHALL be combinational: en & (state==ACC) & ~fifo_empty; fifo_data SHALL be added in the same cycle as fifo_rd.
REQ-022 Back-to-back reads SHALL be allowed, one per cycle, while fifo_empty=0.
REQ-023 When the sample counter reaches 2^latched_avg_log2, the next state SHALL be OUT.
REQ-024 res_data SHALL be accumulator >> latched_avg_log2, truncated toward zero; res_valid SHALL assert the cycle after the last pop.
REQ-025 In OUT, fifo_rd SHALL be 0, and res_data and res_valid SHALL hold until res_valid & res_ready, then go to ACC in the next cycle.
REQ-026 win_flag SHALL pulse for exactly the first OUT cycle when res_data < win_lo or res_data > win_hi; win_lo > win_hi therefore flags every result.
REQ-027 win_cnt SHALL increment with each win_flag and saturate at 255.
REQ-028 With avg_log2=0, every sample SHALL pass through unchanged, with one-cycle latency.

Reset
REQ-029 While rst=1 at a clk edge: state=IDLE, accumulator=0, counter=0, res_data=0, res_valid=0, win_flag=0, win_cnt=0; fifo_rd SHALL be 0 during reset.
REQ-030 Reset mid-window or in OUT SHALL discard all data without popping the FIFO.

Structure
REQ-031 The state encoding and the DW/NMAX_LOG2 defaults SHALL reside in the shared package ef_adc_pkg.
REQ-032 The window comparison SHALL be a single sub-module, ef_adc_win_cmp (combinational lo/hi compare).

Verification
REQ-033 avg_log2=2, FIFO holds 10,20,30,41 back-to-back -> four consecutive fifo_rd pulses; res_data=25 (101>>2), valid one cycle after the 4th pop.
REQ-034 avg_log2=0, win_lo=50, win_hi=100, samples 49,50,100,101, res_ready=1 -> win_flag on 49 and 101 only; win_cnt=2.
REQ-035 Result 200 pending with res_ready=0 for 20 cycles, FIFO non-empty -> fifo_rd stays 0 and res_data stays 200; fifo_rd resumes the cycle after the handshake plus one.
REQ-036 avg_log2=3 with en dropped after 5 pops -> IDLE, no res_valid; re-enable and 8 samples of 255 -> res_data=255 (no overflow).
REQ-037 win_lo=10, win_hi=5, any sample -> win_flag on every result; 300 violations -> win_cnt=255.
REQ-038 rst asserted in OUT with res_valid=1 -> next cycle res_valid=0, res_data=0, win_cnt=0.
